// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between write-back and the CSR file.
//
// Each cycle in IDLE it weighs the synchronous exceptions of the retiring WB
// instruction against pending, enabled interrupts (MEI/MSI/MTI). It then runs
// a fixed-length trap-entry or MRET sequence: a one-cycle CSR strobe with a
// PC redirect, followed by a flush/drain window.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   wb_*                    retiring instruction: valid, PC, word, mem address
//   e_*, ecall_i, ebreak_i  synchronous exception sources of the WB instruction
//   mret_i                  WB instruction is MRET
//   xint_m*p_i              level interrupt pending lines
//   mstatus_mie_i, mie_i    global and per-source interrupt enables {MEI,MTI,MSI}
//   mtvec_i, mepc_i         trap vector and return address CSRs
//   kill_wb_o               combinational: squash the WB register-file write
//   csr_we_trap_o           one-cycle strobe: CSR file captures mepc/mcause/mtval
//   csr_mret_o              one-cycle strobe: CSR file restores MIE from MPIE
//   mepc_o/mcause_o/mtval_o registered trap data, held until the next trap
//   pc_redirect_o           fetch redirect strobe, target on pc_target_o
//   flush_o                 squash all in-flight instructions
//   busy_o                  sequencer is not in IDLE

module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_pc_i,
  input  logic [31:0] wb_inst_i,
  input  logic [31:0] wb_mem_addr_i,
  input  logic        e_inst_addr_mis_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_ld_addr_mis_i,
  input  logic        e_st_addr_mis_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        xint_meip_i,
  input  logic        xint_mtip_i,
  input  logic        xint_msip_i,
  input  logic        mstatus_mie_i,
  input  logic [2:0]  mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        kill_wb_o,
  output logic        csr_we_trap_o,
  output logic        csr_mret_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mtval_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o,
  output logic        flush_o,
  output logic        busy_o
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 4;

  // Drain counter start value: DRAIN lasts exactly FLUSH_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  // Cause codes
  localparam logic [CODE_W-1:0] C_INST_MIS = 4'd0;
  localparam logic [CODE_W-1:0] C_ILLEGAL  = 4'd2;
  localparam logic [CODE_W-1:0] C_BREAK    = 4'd3;
  localparam logic [CODE_W-1:0] C_LD_MIS   = 4'd4;
  localparam logic [CODE_W-1:0] C_ST_MIS   = 4'd6;
  localparam logic [CODE_W-1:0] C_ECALL    = 4'd11;
  localparam logic [CODE_W-1:0] C_MSI      = 4'd3;
  localparam logic [CODE_W-1:0] C_MTI      = 4'd7;
  localparam logic [CODE_W-1:0] C_MEI      = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAP  = 2'd1,
    S_MRET  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_csr_we_trap;
  logic               r_csr_mret;
  logic [XLEN-1:0]    r_mepc;
  logic [XLEN-1:0]    r_mcause;
  logic [XLEN-1:0]    r_mtval;
  logic               r_pc_redirect;
  logic [XLEN-1:0]    r_pc_target;
  logic               r_flush;
  logic               r_busy;

  logic [2:0]         w_int_vec;
  logic               w_int_p;
  logic [CODE_W-1:0]  w_int_code;
  logic               w_exc_any;
  logic [CODE_W-1:0]  w_exc_cause;
  logic [XLEN-1:0]    w_exc_tval;
  logic               w_accept;
  logic               w_take_trap;
  logic               w_take_mret;
  logic [XLEN-1:0]    w_trap_cause;
  logic [XLEN-1:0]    w_trap_tval;
  logic [XLEN-1:0]    w_vec_base;
  logic [XLEN-1:0]    w_trap_target;
  logic [XLEN-1:0]    w_mret_target;

  // Interrupt pending/enable, ordered {MEI, MTI, MSI} to line up with mie_i.
  always_comb begin
    w_int_vec  = {xint_meip_i, xint_mtip_i, xint_msip_i} & mie_i;
    w_int_p    = mstatus_mie_i & (|w_int_vec);
    w_int_code = C_MTI;
    if (w_int_vec[2]) begin
      w_int_code = C_MEI;
    end else if (w_int_vec[0]) begin
      w_int_code = C_MSI;
    end
  end

  // Synchronous exception select: first matching source wins.
  always_comb begin
    w_exc_any   = 1'b1;
    w_exc_cause = C_INST_MIS;
    w_exc_tval  = '0;
    if (e_inst_addr_mis_i) begin
      w_exc_cause = C_INST_MIS;
      w_exc_tval  = wb_pc_i;
    end else if (e_illegal_inst_i) begin
      w_exc_cause = C_ILLEGAL;
      w_exc_tval  = wb_inst_i;
    end else if (ebreak_i) begin
      w_exc_cause = C_BREAK;
      w_exc_tval  = wb_pc_i;
    end else if (ecall_i) begin
      w_exc_cause = C_ECALL;
      w_exc_tval  = '0;
    end else if (e_ld_addr_mis_i) begin
      w_exc_cause = C_LD_MIS;
      w_exc_tval  = wb_mem_addr_i;
    end else if (e_st_addr_mis_i) begin
      w_exc_cause = C_ST_MIS;
      w_exc_tval  = wb_mem_addr_i;
    end else begin
      w_exc_any   = 1'b0;
    end
  end

  // Event acceptance and trap payload; interrupts outrank exceptions, which
  // outrank MRET.
  always_comb begin
    w_accept      = (r_state == S_IDLE) & wb_valid_i;
    w_take_trap   = w_accept & (w_int_p | w_exc_any);
    w_take_mret   = w_accept & ~w_int_p & ~w_exc_any & mret_i;

    w_trap_cause  = w_int_p ? {1'b1, 27'b0, w_int_code}
                            : {1'b0, 27'b0, w_exc_cause};
    w_trap_tval   = w_int_p ? '0 : w_exc_tval;

    // Vectored mode (mtvec[1:0]==01) offsets only interrupts by 4*code.
    w_vec_base    = {mtvec_i[31:2], 2'b00};
    w_trap_target = w_vec_base;
    if (w_int_p && (mtvec_i[1:0] == 2'b01)) begin
      w_trap_target = w_vec_base + {26'b0, w_int_code, 2'b00};
    end
    w_mret_target = {mepc_i[31:2], 2'b00};
  end

  assign kill_wb_o = w_take_trap;

  // Sequencer with registered strobes and trap data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_csr_we_trap <= 1'b0;
      r_csr_mret    <= 1'b0;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
      r_pc_redirect <= 1'b0;
      r_pc_target   <= '0;
      r_flush       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take_trap) begin
            r_state       <= S_TRAP;
            r_mepc        <= wb_pc_i;
            r_mcause      <= w_trap_cause;
            r_mtval       <= w_trap_tval;
            r_csr_we_trap <= 1'b1;
            r_pc_redirect <= 1'b1;
            r_pc_target   <= w_trap_target;
            r_flush       <= 1'b1;
            r_busy        <= 1'b1;
          end else if (w_take_mret) begin
            r_state       <= S_MRET;
            r_csr_mret    <= 1'b1;
            r_pc_redirect <= 1'b1;
            r_pc_target   <= w_mret_target;
            r_flush       <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        S_TRAP, S_MRET: begin
          // Strobes last one cycle; flush and busy carry on through DRAIN.
          r_state       <= S_DRAIN;
          r_cnt         <= CNT_LOAD;
          r_csr_we_trap <= 1'b0;
          r_csr_mret    <= 1'b0;
          r_pc_redirect <= 1'b0;
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign csr_we_trap_o = r_csr_we_trap;
  assign csr_mret_o    = r_csr_mret;
  assign mepc_o        = r_mepc;
  assign mcause_o      = r_mcause;
  assign mtval_o       = r_mtval;
  assign pc_redirect_o = r_pc_redirect;
  assign pc_target_o   = r_pc_target;
  assign flush_o       = r_flush;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a vector table of single events with hand-computed
// expected results, a scoreboard of expected strobes popped by a monitor, and
// hand-written sequences for reset, DRAIN-ignore and mid-sequence reset.

module tb_trap_ctrl;

  localparam int unsigned FLUSH = 3;
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_TRAP = 2'd1;
  localparam logic [1:0] K_MRET = 2'd2;

  // exc bits: {inst_mis, illegal, ebreak, ecall, ld_mis, st_mis, mret}
  // ip bits:  {meip, mtip, msip}
  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] mem;
    logic [6:0]  exc;
    logic [2:0]  ip;
    logic        gie;
    logic [2:0]  mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        e_kill;
    logic [1:0]  e_kind;
    logic [31:0] e_mepc;
    logic [31:0] e_mcause;
    logic [31:0] e_mtval;
    logic [31:0] e_target;
  } vec_t;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] target;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i, wb_inst_i, wb_mem_addr_i;
  logic        e_inst_addr_mis_i, e_illegal_inst_i, e_ld_addr_mis_i, e_st_addr_mis_i;
  logic        ecall_i, ebreak_i, mret_i;
  logic        xint_meip_i, xint_mtip_i, xint_msip_i;
  logic        mstatus_mie_i;
  logic [2:0]  mie_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        kill_wb_o, csr_we_trap_o, csr_mret_o;
  logic [31:0] mepc_o, mcause_o, mtval_o;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic        flush_o, busy_o;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  trap_ctrl #(.FLUSH_CYCLES(FLUSH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i), .wb_inst_i(wb_inst_i),
    .wb_mem_addr_i(wb_mem_addr_i),
    .e_inst_addr_mis_i(e_inst_addr_mis_i), .e_illegal_inst_i(e_illegal_inst_i),
    .e_ld_addr_mis_i(e_ld_addr_mis_i), .e_st_addr_mis_i(e_st_addr_mis_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .xint_meip_i(xint_meip_i), .xint_mtip_i(xint_mtip_i), .xint_msip_i(xint_msip_i),
    .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .kill_wb_o(kill_wb_o), .csr_we_trap_o(csr_we_trap_o), .csr_mret_o(csr_mret_o),
    .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
    .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o),
    .flush_o(flush_o), .busy_o(busy_o)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic idle_inputs();
    wb_valid_i = 1'b0; wb_pc_i = '0; wb_inst_i = '0; wb_mem_addr_i = '0;
    {e_inst_addr_mis_i, e_illegal_inst_i, ebreak_i, ecall_i,
     e_ld_addr_mis_i, e_st_addr_mis_i, mret_i} = 7'b0;
    {xint_meip_i, xint_mtip_i, xint_msip_i} = 3'b0;
    mstatus_mie_i = 1'b0; mie_i = 3'b0;
  endtask

  task automatic drive(input vec_t v);
    wb_valid_i = v.valid; wb_pc_i = v.pc; wb_inst_i = v.inst; wb_mem_addr_i = v.mem;
    {e_inst_addr_mis_i, e_illegal_inst_i, ebreak_i, ecall_i,
     e_ld_addr_mis_i, e_st_addr_mis_i, mret_i} = v.exc;
    {xint_meip_i, xint_mtip_i, xint_msip_i} = v.ip;
    mstatus_mie_i = v.gie; mie_i = v.mie; mtvec_i = v.mtvec; mepc_i = v.mepc;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.kind = v.e_kind; e.mepc = v.e_mepc; e.mcause = v.e_mcause;
    e.mtval = v.e_mtval; e.target = v.e_target;
    if (v.e_kind != K_NONE) sb_q.push_back(e);
  endtask

  // Drive one event in cycle N, then observe flush length and busy release.
  task automatic run_vec(input vec_t v, input int idx);
    int flush_cnt;
    int busy_low_at;
    @(posedge clk); #1;
    drive(v);
    #1;
    chk($sformatf("vec%0d_kill", idx), 32'(kill_wb_o), 32'(v.e_kill));
    push_exp(v);
    @(posedge clk); #1;
    idle_inputs();
    flush_cnt = 0;
    busy_low_at = 0;
    for (int k = 1; k <= int'(FLUSH) + 4; k++) begin
      @(negedge clk);
      if (flush_o) flush_cnt++;
      if (!busy_o && busy_low_at == 0) busy_low_at = k;
    end
    chk($sformatf("vec%0d_flush_len", idx), 32'(flush_cnt),
        (v.e_kind == K_NONE) ? 32'd0 : 32'(FLUSH + 1));
    chk($sformatf("vec%0d_busy_release", idx), 32'(busy_low_at),
        (v.e_kind == K_NONE) ? 32'd1 : 32'(FLUSH + 2));
  endtask

  // Scoreboard monitor: every strobe cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (csr_we_trap_o || csr_mret_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: trap=%0b mret=%0b with nothing expected at %0t",
                 csr_we_trap_o, csr_mret_o, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_trap_strobe", 32'(csr_we_trap_o), 32'(e.kind == K_TRAP));
        chk("sb_mret_strobe", 32'(csr_mret_o), 32'(e.kind == K_MRET));
        chk("sb_redirect", 32'(pc_redirect_o), 32'd1);
        chk("sb_target", pc_target_o, e.target);
        if (e.kind == K_TRAP) begin
          chk("sb_mepc", mepc_o, e.mepc);
          chk("sb_mcause", mcause_o, e.mcause);
          chk("sb_mtval", mtval_o, e.mtval);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_flush"}, 32'(flush_o), 32'd0);
    chk({tag, "_trap"}, 32'(csr_we_trap_o), 32'd0);
    chk({tag, "_mret"}, 32'(csr_mret_o), 32'd0);
    chk({tag, "_redirect"}, 32'(pc_redirect_o), 32'd0);
    chk({tag, "_mepc"}, mepc_o, 32'd0);
    chk({tag, "_mcause"}, mcause_o, 32'd0);
    chk({tag, "_mtval"}, mtval_o, 32'd0);
    chk({tag, "_target"}, pc_target_o, 32'd0);
  endtask

  initial begin
    vec_t v;
    // valid pc inst mem exc ip gie mie mtvec mepc | kill kind mepc mcause mtval target
    vecs.push_back('{1'b1, 32'h100, 32'hFFFF_FFFF, 32'h0, 7'b0100000, 3'b000, 1'b0, 3'b000, 32'h200, 32'h0,
                     1'b1, K_TRAP, 32'h100, 32'h2, 32'hFFFF_FFFF, 32'h200});
    vecs.push_back('{1'b1, 32'h40, 32'h0, 32'h0, 7'b0000000, 3'b110, 1'b1, 3'b111, 32'h201, 32'h0,
                     1'b1, K_TRAP, 32'h40, 32'h8000_000B, 32'h0, 32'h22C});
    vecs.push_back('{1'b1, 32'h44, 32'h0, 32'h0, 7'b0000000, 3'b010, 1'b0, 3'b010, 32'h200, 32'h0,
                     1'b0, K_NONE, 32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h48, 32'h0, 32'h0, 7'b0000001, 3'b000, 1'b0, 3'b000, 32'h200, 32'h1236,
                     1'b0, K_MRET, 32'h0, 32'h0, 32'h0, 32'h1234});
    vecs.push_back('{1'b1, 32'h80, 32'h0, 32'h3, 7'b0001100, 3'b000, 1'b0, 3'b000, 32'h200, 32'h0,
                     1'b1, K_TRAP, 32'h80, 32'hB, 32'h0, 32'h200});
    vecs.push_back('{1'b1, 32'h102, 32'h1234, 32'h0, 7'b1100000, 3'b000, 1'b0, 3'b000, 32'h200, 32'h0,
                     1'b1, K_TRAP, 32'h102, 32'h0, 32'h102, 32'h200});
    vecs.push_back('{1'b1, 32'h300, 32'h0, 32'h0, 7'b0011000, 3'b000, 1'b0, 3'b000, 32'h200, 32'h0,
                     1'b1, K_TRAP, 32'h300, 32'h3, 32'h300, 32'h200});
    vecs.push_back('{1'b1, 32'h50, 32'h0, 32'h1001, 7'b0000010, 3'b000, 1'b0, 3'b000, 32'h200, 32'h0,
                     1'b1, K_TRAP, 32'h50, 32'h6, 32'h1001, 32'h200});
    vecs.push_back('{1'b1, 32'h54, 32'h1234_5678, 32'h0, 7'b0100001, 3'b000, 1'b0, 3'b000, 32'h200, 32'h888,
                     1'b1, K_TRAP, 32'h54, 32'h2, 32'h1234_5678, 32'h200});
    vecs.push_back('{1'b1, 32'h60, 32'h0, 32'h0, 7'b0000001, 3'b001, 1'b1, 3'b001, 32'h205, 32'h888,
                     1'b1, K_TRAP, 32'h60, 32'h8000_0003, 32'h0, 32'h210});
    vecs.push_back('{1'b1, 32'h70, 32'h0, 32'h0, 7'b0000000, 3'b010, 1'b1, 3'b010, 32'h400, 32'h0,
                     1'b1, K_TRAP, 32'h70, 32'h8000_0007, 32'h0, 32'h400});
    vecs.push_back('{1'b1, 32'h74, 32'h0, 32'h0, 7'b0000000, 3'b011, 1'b1, 3'b011, 32'h401, 32'h0,
                     1'b1, K_TRAP, 32'h74, 32'h8000_0003, 32'h0, 32'h40C});
    vecs.push_back('{1'b1, 32'h78, 32'hDEAD_BEEF, 32'h0, 7'b0100000, 3'b000, 1'b0, 3'b000, 32'h201, 32'h0,
                     1'b1, K_TRAP, 32'h78, 32'h2, 32'hDEAD_BEEF, 32'h200});
    vecs.push_back('{1'b0, 32'h7C, 32'h1, 32'h0, 7'b0100000, 3'b100, 1'b1, 3'b100, 32'h200, 32'h0,
                     1'b0, K_NONE, 32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h90, 32'h0, 32'hABCD, 7'b0000100, 3'b100, 1'b1, 3'b011, 32'h203, 32'h0,
                     1'b1, K_TRAP, 32'h90, 32'h4, 32'hABCD, 32'h200});

    idle_inputs();
    mtvec_i = '0; mepc_i = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_kill", 32'(kill_wb_o), 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Exception raised during DRAIN is ignored.
    v = vecs[0];
    @(posedge clk); #1;
    drive(v); push_exp(v);
    @(posedge clk); #1; idle_inputs();
    @(posedge clk); #1;
    wb_valid_i = 1'b1; e_illegal_inst_i = 1'b1; wb_pc_i = 32'h500; wb_inst_i = 32'h5;
    #1;
    chk("drain_ignore_kill", 32'(kill_wb_o), 32'd0);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk); @(negedge clk);
    chk("drain_ignore_busy_n4", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("drain_ignore_busy_n5", 32'(busy_o), 32'd0);
    chk("drain_ignore_mepc_held", mepc_o, 32'h100);

    // Reset pulsed during DRAIN aborts the sequence.
    v = vecs[6];
    @(posedge clk); #1;
    drive(v); push_exp(v);
    @(posedge clk); #1; idle_inputs();
    @(posedge clk); #1;
    chk("midrst_in_drain", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check_all_zero("midrst");
    run_vec(vecs[1], 100);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer between the write-back stage and the CSR file. Each cycle it arbitrates the synchronous exceptions of the retiring instruction against pending enabled interrupts (MEI/MSI/MTI), and sequences trap entry and MRET. Trap entry and MRET are fixed-length sequences: a CSR update strobe, a PC redirect, and a pipeline flush/drain window.

## Interface
- FLUSH_CYCLES, 3, cycles flush_o stays high after the TRAP/MRET cycle (legal range 1..15)
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- wb_valid_i  in  1  valid instruction in WB this cycle
- wb_pc_i  in  32  PC of WB instruction
- wb_inst_i  in  32  WB instruction word
- wb_mem_addr_i  in  32  effective address of WB load/store
- e_inst_addr_mis_i, e_illegal_inst_i, e_ld_addr_mis_i, e_st_addr_mis_i  in  1 each  WB exception flags
- ecall_i, ebreak_i, mret_i  in  1 each  decoded WB SYSTEM instructions
- xint_meip_i, xint_mtip_i, xint_msip_i  in  1 each  interrupt pending lines (level)
- mstatus_mie_i  in  1  global interrupt enable
- mie_i  in  3  {meie, mtie, msie}
- mtvec_i  in  32  trap vector CSR
- mepc_i  in  32  current mepc CSR
- kill_wb_o  out  1  combinational; suppresses the register-file write of the WB instruction
- csr_we_trap_o  out  1  one-cycle strobe: CSR file writes mepc/mcause/mtval, MPIE<=MIE, MIE<=0
- csr_mret_o  out  1  one-cycle strobe: CSR file sets MIE<=MPIE, MPIE<=1
- mepc_o, mcause_o, mtval_o  out  32 each  registered trap data, valid while csr_we_trap_o=1
- pc_redirect_o  out  1  fetch redirect strobe
- pc_target_o  out  32  redirect target, valid while pc_redirect_o=1
- flush_o  out  1  squash all in-flight instructions
- busy_o  out  1  high whenever state != IDLE

## Operation
- States: IDLE, TRAP, MRET, DRAIN. An event is only accepted in IDLE with wb_valid_i=1. In any other state, all inputs are ignored.
- Interrupt pending: int_p = mstatus_mie_i & |({xint_meip_i, xint_mtip_i, xint_msip_i} & mie_i).
- Priority in IDLE, highest first:
  - interrupt: MEI (code 11), then MSI (3), then MTI (7)
  - synchronous exceptions, in this order:
    - inst_addr_mis: cause 0, tval = wb_pc_i
    - illegal: cause 2, tval = wb_inst_i
    - ebreak: cause 3, tval = wb_pc_i
    - ecall: cause 11, tval = 0
    - ld_mis: cause 4, tval = wb_mem_addr_i
    - st_mis: cause 6, tval = wb_mem_addr_i
  - mret
- Interrupt taken: kill_wb_o=1 and the WB instruction is squashed. mepc = wb_pc_i (the instruction re-executes after return). mcause = {1'b1, 27'b0, code}. mtval = 0. Next state TRAP.
- Exception taken: kill_wb_o=1. mepc = wb_pc_i. mcause = {1'b0, 27'b0, cause}. Next state TRAP.
- MRET accepted (no exception or interrupt present): kill_wb_o=0. Next state MRET.
- TRAP cycle:
  - csr_we_trap_o=1, pc_redirect_o=1, flush_o=1.
  - pc_target_o = {mtvec_i[31:2], 2'b00}.
  - If mtvec_i[1:0]==2'b01 and the trap is an interrupt: pc_target_o = {mtvec_i[31:2], 2'b00} + (code << 2), 32-bit wrap.
  - Next state DRAIN.
- MRET cycle: csr_mret_o=1, pc_redirect_o=1, flush_o=1, pc_target_o = {mepc_i[31:2], 2'b00}. Next state DRAIN.
- DRAIN: flush_o=1. A 4-bit counter loads FLUSH_CYCLES-1 on entry and decrements each cycle. The state exits to IDLE on the cycle the counter reads 0.
- Simultaneous events:
  - mret together with an exception: the exception wins.
  - mret together with an interrupt: the interrupt wins, with mepc = PC of the mret.
  - Several exception flags: the highest-priority one only.

## Timing
- Reset: state IDLE, counter 0. All outputs 0, including mepc_o, mcause_o, mtval_o and pc_target_o. Reset takes effect at the next edge from any state, aborting a sequence in progress; no strobe is issued afterwards.
- kill_wb_o is combinational in the accepting IDLE cycle N.
- Cycle N+1: TRAP or MRET; the strobes are high for exactly one cycle.
- Cycles N+2 .. N+1+FLUSH_CYCLES: DRAIN.
- Next event accepted at cycle N+2+FLUSH_CYCLES.
- Total busy duration: 1+FLUSH_CYCLES cycles.
- mepc_o, mcause_o and mtval_o are registered at edge N and held until the next accepted trap.

## Test plan
- Illegal instruction: wb_valid=1, e_illegal=1, wb_inst=0xFFFFFFFF, wb_pc=0x100, mtvec=0x200 -> kill_wb=1 at N; at N+1 csr_we_trap=1, mcause=2, mtval=0xFFFFFFFF, mepc=0x100, pc_target=0x200; flush high 4 cycles; busy back to 0 at N+5.
- Vectored interrupt: mtvec=0x201, mie=3'b111, mstatus_mie=1, meip=mtip=1, wb_pc=0x40 -> mcause=0x8000000B, mepc=0x40, mtval=0, pc_target=0x22C.
- Masked interrupt: mtip=1, mie=3'b010, mstatus_mie=0 -> no trap, kill_wb=0, busy=0.
- MRET: mret=1, mepc=0x1236 -> csr_mret=1 and pc_target=0x1234 at N+1; kill_wb=0.
- Priority and ignore: e_ld_mis=1 with ecall=1, mem_addr=0x3 -> mcause=11, mtval=0. A second exception asserted during DRAIN is ignored.
- Reset mid-sequence: rst_i pulsed during DRAIN -> IDLE and all outputs 0 next cycle; an event on the following cycle is accepted normally.
